param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO, successor to the team's fixed-size FIFO.
- Adds configurable data width and depth, almost-full/almost-empty thresholds, overflow/underflow pulses and a synchronous flush.
- Keeps the rd/wr/din/dout/full/empty/fifo_cnt/rd_ptr/wr_ptr port set so existing env/monitor/scoreboard components carry over with parameter changes only.
- Sits between a producer and a consumer in the same clock domain.

---
 rtl/param_sync_fifo.sv | 108 ++++++++++
 tb/tb_param_sync_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// synchronous flush. Reset is synchronous and active-low.
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through mode. In that
// mode dout shows the head word combinationally, reads 0 when empty, and rd
// pops that word. Without the macro, dout is registered and a read returns
// its word one cycle after the request.
//
// The count is one bit wider than the pointers so that full (DEPTH) and
// empty (0) stay distinct while the pointers wrap freely.

module param_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [CW-1:0]     fifo_cnt,
  output logic [AW-1:0]     wr_ptr,
  output logic [AW-1:0]     rd_ptr
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_acc;
  logic              wr_acc;
  logic [CW-1:0]     cnt_nxt;

  // Status flags are decoded from the registered count only.
  assign empty        = (fifo_cnt == '0);
  assign full         = (fifo_cnt == CW'(DEPTH));
  assign almost_full  = (fifo_cnt >= CW'(AF_LEVEL));
  assign almost_empty = (fifo_cnt <= CW'(AE_LEVEL));

  // Accept decode: a read frees a slot, so a full FIFO still takes a write
  // when it is read in the same cycle.
  always_comb begin
    rd_acc  = rd && !empty;
    wr_acc  = wr && (!full || rd_acc);
    cnt_nxt = fifo_cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = fifo_cnt + CW'(1);
      2'b01:   cnt_nxt = fifo_cnt - CW'(1);
      default: cnt_nxt = fifo_cnt;
    endcase
  end

  // Storage write; contents survive reset and flush, only the pointers move.
  always_ff @(posedge clk) begin
    if (rst && !flush && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and the one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural AW-bit rollover is the wrap.
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt  <= cnt_nxt;
      overflow  <= wr && !wr_acc;
      underflow <= rd && !rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; forced to zero so an empty FIFO shows no stale data.
  assign dout = empty ? '0 : mem[rd_ptr];
`else
  // Registered read data: loads on an accepted read, holds through flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout <= '0;
    end else if (!flush && rd_acc) begin
      dout <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DATA_W=8, DEPTH=8, AF=6, AE=2).
// Table rows cover reset, fill/drain, boundary errors and simultaneous
// access; hand-written sequences cover pointer wrap, flush and FWFT.

module tb_param_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;

  logic       clk = 1'b0;
  logic       rst, wr, rd, flush;
  logic [7:0] din, dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] fifo_cnt;
  logic [2:0] wr_ptr, rd_ptr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .flush(flush),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow),
    .fifo_cnt(fifo_cnt), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr)
  );

  typedef struct {
    logic       rst, flush, wr, rd;
    logic [7:0] din;
    int         cnt;
    logic       ov, ud;
    logic [7:0] dout;
    int         wp, rp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic w, input logic rdq,
                     input logic [7:0] d, input int cnt, input logic ov, input logic ud,
                     input logic [7:0] dexp, input int wp, input int rp);
    vec_t v;
    v.rst = r; v.flush = f; v.wr = w; v.rd = rdq; v.din = d; v.cnt = cnt;
    v.ov = ov; v.ud = ud; v.dout = dexp; v.wp = wp; v.rp = rp;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic w, input logic rdq,
                       input logic [7:0] d);
    rst = r; flush = f; wr = w; rd = rdq; din = d;
  endtask

  // Flags derived from the expected occupancy and the threshold definitions.
  task automatic check_status(input string tag, input int cnt);
    check({tag, " cnt"},   int'(fifo_cnt),     cnt);
    check({tag, " empty"}, int'(empty),        int'(cnt == 0));
    check({tag, " full"},  int'(full),         int'(cnt == DEPTH));
    check({tag, " af"},    int'(almost_full),  int'(cnt >= AF));
    check({tag, " ae"},    int'(almost_empty), int'(cnt <= AE));
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] last_dout;
    logic [7:0] popped;
    logic       w, r, racc, wacc;
    int         guard;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // ---- vector table (standard-mode dout expectations) ----
    // reset held two cycles with a write request that must be ignored
    add(0,0,1,0,8'hAA, 0,0,0,8'h00, 0,0);
    add(0,0,1,0,8'hAA, 0,0,0,8'h00, 0,0);
    add(1,0,0,0,8'h00, 0,0,0,8'h00, 0,0);
    // fill 01..08
    for (int i = 1; i <= 8; i++) add(1,0,1,0,8'(i), i,0,0,8'h00, i % 8,0);
    // write while full: rejected, overflow pulses once
    add(1,0,1,0,8'h09, 8,1,0,8'h00, 0,0);
    add(1,0,0,0,8'h00, 8,0,0,8'h00, 0,0);
    // drain: data in order, overflowed write did not corrupt slot 0
    for (int i = 1; i <= 8; i++) add(1,0,0,1,8'h00, 8-i,0,0,8'(i), 0,i % 8);
    // read while empty: underflow pulses, dout holds
    add(1,0,0,1,8'h00, 0,0,1,8'h08, 0,0);
    add(1,0,0,0,8'h00, 0,0,0,8'h08, 0,0);
    // refill 11..18
    for (int i = 1; i <= 8; i++) add(1,0,1,0,8'(8'h10 + i), i,0,0,8'h08, i % 8,0);
    // full with rd=wr: both accepted, oldest out, no overflow
    add(1,0,1,1,8'h19, 8,0,0,8'h11, 1,1);
    for (int i = 2; i <= 9; i++) add(1,0,0,1,8'h00, 9-i,0,0,8'(8'h10 + i), 1,i % 8);
    // empty with rd=wr: write in, read rejected
    add(1,0,1,1,8'h2A, 1,0,1,8'h19, 2,1);
    add(1,0,0,1,8'h00, 0,0,0,8'h2A, 2,2);

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("v%0d", k);
      drive(vecs[k].rst, vecs[k].flush, vecs[k].wr, vecs[k].rd, vecs[k].din);
      step();
      check_status(tag, vecs[k].cnt);
      check({tag, " ovf"}, int'(overflow),  int'(vecs[k].ov));
      check({tag, " udf"}, int'(underflow), int'(vecs[k].ud));
      check({tag, " wp"},  int'(wr_ptr),    vecs[k].wp);
      check({tag, " rp"},  int'(rd_ptr),    vecs[k].rp);
`ifndef FIFO_FWFT_EN
      check({tag, " dout"}, int'(dout), int'(vecs[k].dout));
`endif
    end

    // ---- mixed traffic across pointer wrap, scoreboard model ----
    q.delete();
    last_dout = 8'h2A;
    for (int i = 0; i < 40; i++) begin
      w = (i % 4) != 3;
      r = (i % 3) == 1;
      racc = r && (q.size() > 0);
      wacc = w && ((q.size() < DEPTH) || racc);
`ifdef FIFO_FWFT_EN
      if (racc) check($sformatf("mix%0d head", i), int'(dout), int'(q[0]));
`endif
      drive(1'b1, 1'b0, w, r, 8'(8'h40 + i));
      popped = 8'h00;
      if (racc) popped = q.pop_front();
      if (wacc) q.push_back(8'(8'h40 + i));
      step();
      check_status($sformatf("mix%0d", i), q.size());
      check($sformatf("mix%0d ovf", i), int'(overflow),  int'(w && !wacc));
      check($sformatf("mix%0d udf", i), int'(underflow), int'(r && !racc));
`ifndef FIFO_FWFT_EN
      if (racc) last_dout = popped;
      check($sformatf("mix%0d dout", i), int'(dout), int'(last_dout));
`endif
    end

    // bring occupancy to 5 with a bounded loop
    guard = 0;
    while (q.size() != 5 && guard < 20) begin
      if (q.size() > 5) begin
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        last_dout = q.pop_front();
      end else begin
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h70);
        q.push_back(8'h70);
      end
      step();
      guard++;
    end
    check("level5 reached", int'(q.size() == 5), 1);
    check_status("pre-flush", 5);

    // flush with rd=wr=1: everything cleared, no pulses, dout held
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hEE);
    step();
    check_status("flush", 0);
    check("flush ovf", int'(overflow), 0);
    check("flush udf", int'(underflow), 0);
    check("flush wp", int'(wr_ptr), 0);
    check("flush rp", int'(rd_ptr), 0);
`ifndef FIFO_FWFT_EN
    check("flush dout", int'(dout), int'(last_dout));
`else
    check("flush dout", int'(dout), 0);
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("post-flush ovf", int'(overflow), 0);
    check("post-flush udf", int'(underflow), 0);

    // data path works after flush
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hA1);
    step();
    check_status("pf write", 1);
`ifdef FIFO_FWFT_EN
    check("pf fwft head", int'(dout), 8'hA1);
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    check_status("pf read", 0);
`ifndef FIFO_FWFT_EN
    check("pf dout", int'(dout), 8'hA1);
`else
    check("pf dout empty", int'(dout), 0);

    // ---- FWFT: word visible the cycle after its write, rd pops it ----
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("fwft reset dout", int'(dout), 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
    step();
    check("fwft fallthrough", int'(dout), 8'h5A);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("fwft hold", int'(dout), 8'h5A);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    check_status("fwft pop", 0);
    check("fwft dout after pop", int'(dout), 0);
`endif

    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
